l1_line_fill_writer: RTL

Write-port front end for the L1 data array: the 256-set, 1024-bit-line SRAM with one write port (active-low chip select, per-byte mask, registered inputs) and one read port.
- Assembles refill beats from the memory side into a full 1024-bit line and issues it as one full-mask write.
- Arbitrates that write against byte-masked store writes from the LSU.
- Every SRAM write-port input is driven from a flop, so the array samples clean values.

---
 rtl/l1_line_fill_writer_if.sv | 43 ++++
 rtl/l1_line_fill_writer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/l1_line_fill_writer_if.sv
// Handshake and SRAM write-port bundle for l1_line_fill_writer.
// master = cache controller / memory side, slave = the fill writer.
interface l1_line_fill_writer_if #(
    parameter int LINE_BITS = 1024,
    parameter int BEAT_BITS = 64,
    parameter int SET_BITS  = 8
);
    localparam int WMASK_BITS = LINE_BITS / 8;

    logic                  fill_req_valid;
    logic [SET_BITS-1:0]   fill_req_set;
    logic                  fill_req_ready;
    logic                  beat_valid;
    logic [BEAT_BITS-1:0]  beat_data;
    logic                  beat_ready;
    logic                  store_valid;
    logic [SET_BITS-1:0]   store_set;
    logic [WMASK_BITS-1:0] store_wmask;
    logic [LINE_BITS-1:0]  store_data;
    logic                  store_ready;
    logic                  sram_csb0;
    logic [WMASK_BITS-1:0] sram_wmask0;
    logic [SET_BITS-1:0]   sram_addr0;
    logic [LINE_BITS-1:0]  sram_din0;
    logic                  fill_done;
    logic [SET_BITS-1:0]   fill_done_set;

    modport master (
        output fill_req_valid, fill_req_set, beat_valid, beat_data,
               store_valid, store_set, store_wmask, store_data,
        input  fill_req_ready, beat_ready, store_ready,
               sram_csb0, sram_wmask0, sram_addr0, sram_din0,
               fill_done, fill_done_set
    );

    modport slave (
        input  fill_req_valid, fill_req_set, beat_valid, beat_data,
               store_valid, store_set, store_wmask, store_data,
        output fill_req_ready, beat_ready, store_ready,
               sram_csb0, sram_wmask0, sram_addr0, sram_din0,
               fill_done, fill_done_set
    );
endinterface

// File: rtl/l1_line_fill_writer.sv
// L1 data-array write front end: assembles refill beats into a line and arbitrates
// it against LSU stores; all SRAM write inputs are flopped. Option: L1_STORE_MERGE_EN.
module l1_line_fill_writer #(
    parameter int LINE_BITS = 1024,
    parameter int BEAT_BITS = 64,
    parameter int SET_BITS  = 8
) (
    input logic                   clk,
    input logic                   rst,
    l1_line_fill_writer_if.slave  bus
);
    localparam int BEATS      = LINE_BITS / BEAT_BITS;
    localparam int WMASK_BITS = LINE_BITS / 8;
    localparam int BEAT_BYTES = BEAT_BITS / 8;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [SET_BITS-1:0]   fill_set_q;
    logic [LINE_BITS-1:0]  line_q, line_d;
    logic [WMASK_BITS-1:0] sticky_q;
    logic                  fill_rdy, beat_rdy, store_rdy;
    logic                  fill_acc, beat_acc, store_acc, last_beat, set_hit, store_merge;

    assign fill_acc  = bus.fill_req_valid & fill_rdy;
    assign beat_acc  = bus.beat_valid & beat_rdy;
    assign store_acc = bus.store_valid & store_rdy;
    assign last_beat = (state_q == COLLECT) && bus.beat_valid && (cnt_q == CNT_W'(BEATS - 1));
    assign set_hit   = (state_q == COLLECT) && (bus.store_set == fill_set_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_acc)  state_d = COLLECT;
            COLLECT: if (last_beat) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The last beat owns the output flops; same-set stores either stall or merge.
    always_comb begin
        fill_rdy = (state_q == IDLE);
        beat_rdy = (state_q == COLLECT);
`ifdef L1_STORE_MERGE_EN
        store_rdy = !last_beat;
`else
        store_rdy = !last_beat && !set_hit;
`endif
    end

    assign bus.fill_req_ready = fill_rdy;
    assign bus.beat_ready     = beat_rdy;
    assign bus.store_ready    = store_rdy;

`ifdef L1_STORE_MERGE_EN
    assign store_merge = store_acc && set_hit;

    always_ff @(posedge clk) begin
        if (rst || fill_acc) sticky_q <= '0;
        else if (store_merge) sticky_q <= sticky_q | bus.store_wmask;
    end
`else
    assign store_merge = 1'b0;
    assign sticky_q    = '0;
`endif

    // Merged store bytes win over a same-cycle beat; sticky bytes survive later beats.
    always_comb begin
        line_d = line_q;
        for (int b = 0; b < WMASK_BITS; b++) begin
            if (store_merge && bus.store_wmask[b])
                line_d[8*b +: 8] = bus.store_data[8*b +: 8];
            else if (beat_acc && ((b / BEAT_BYTES) == int'(cnt_q)) && !sticky_q[b])
                line_d[8*b +: 8] = bus.beat_data[(b % BEAT_BYTES)*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            fill_set_q <= '0;
        end else if (fill_acc) begin
            cnt_q      <= '0;
            fill_set_q <= bus.fill_req_set;
        end else if (beat_acc) begin
            cnt_q      <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sram_csb0     <= 1'b1;
            bus.sram_wmask0   <= '0;
            bus.sram_addr0    <= '0;
            bus.sram_din0     <= '0;
            bus.fill_done     <= 1'b0;
            bus.fill_done_set <= '0;
        end else begin
            bus.sram_csb0 <= 1'b1;
            bus.fill_done <= last_beat;
            if (last_beat) begin
                bus.sram_csb0     <= 1'b0;
                bus.sram_wmask0   <= '1;
                bus.sram_addr0    <= fill_set_q;
                bus.sram_din0     <= line_d;
                bus.fill_done_set <= fill_set_q;
            end else if (store_acc && !store_merge) begin
                bus.sram_csb0   <= 1'b0;
                bus.sram_wmask0 <= bus.store_wmask;
                bus.sram_addr0  <= bus.store_set;
                bus.sram_din0   <= bus.store_data;
            end
        end
    end
endmodule
